aux_uart_bridge: RTL

AUX_UART_BRIDGE -- requirements
Module: aux_uart_bridge

---
 rtl/aux_uart_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aux_uart_bridge.sv
// aux_uart_bridge: byte-wide aux register window in front of CHANNELS
// UART stream pairs. Each channel has a TX FIFO, an RX FIFO, sticky
// overflow flags and interrupt enables.

// One channel: TX/RX FIFOs, sticky flags and CTRL.
module aux_uart_chan #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       data_wr_i,
   input  logic       data_rd_i,
   input  logic       status_wr_i,
   input  logic       ctrl_wr_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] tx_tdata_o,
   output logic       tx_tvalid_o,
   input  logic       tx_tready_i,
   input  logic [7:0] rx_tdata_i,
   input  logic       rx_tvalid_i,
   output logic [7:0] rx_head_o,
   output logic [7:0] status_o,
   output logic [7:0] ctrl_o,
   output logic [7:0] rxcnt_o,
   output logic       irq_cond_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [7:0]    tx_mem_q [FIFO_DEPTH];
   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          tx_empty, tx_full, tx_deq, tx_acc;
   logic          rx_empty, rx_full, rx_pop, rx_acc;

   // FIFO bookkeeping; a full FIFO accepts only when it is drained at the same edge
   always_comb begin
      tx_empty  = (tx_cnt_q == '0);
      tx_full   = (tx_cnt_q == FULL);
      tx_deq    = ~tx_empty & tx_tready_i;
      tx_acc    = data_wr_i & (~tx_full | tx_deq);
      rx_empty  = (rx_cnt_q == '0);
      rx_full   = (rx_cnt_q == FULL);
      rx_pop    = data_rd_i & ~rx_empty;
      rx_acc    = rx_tvalid_i & (~rx_full | rx_pop);
      tx_wptr_d = tx_wptr_q + AW'(tx_acc);
      tx_rptr_d = tx_rptr_q + AW'(tx_deq);
      tx_cnt_d  = tx_cnt_q + CW'(tx_acc) - CW'(tx_deq);
      rx_wptr_d = rx_wptr_q + AW'(rx_acc);
      rx_rptr_d = rx_rptr_q + AW'(rx_pop);
      rx_cnt_d  = rx_cnt_q + CW'(rx_acc) - CW'(rx_pop);
      // a new overflow wins over a write-1-to-clear in the same cycle
      tx_ovf_d  = (data_wr_i & tx_full & ~tx_deq) |
                  (tx_ovf_q & ~(status_wr_i & wdata_i[4]));
      rx_ovf_d  = (rx_tvalid_i & rx_full & ~rx_pop) |
                  (rx_ovf_q & ~(status_wr_i & wdata_i[2]));
      ctrl_d    = ctrl_wr_i ? wdata_i[1:0] : ctrl_q;
   end

   // state registers, synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
         tx_ovf_q  <= 1'b0;
         rx_ovf_q  <= 1'b0;
         ctrl_q    <= '0;
      end else begin
         tx_wptr_q <= tx_wptr_d;
         tx_rptr_q <= tx_rptr_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_wptr_q <= rx_wptr_d;
         rx_rptr_q <= rx_rptr_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_ovf_q  <= tx_ovf_d;
         rx_ovf_q  <= rx_ovf_d;
         ctrl_q    <= ctrl_d;
      end
   end

   // FIFO storage; contents are don't-care once the counts are reset
   always_ff @(posedge clk_i) begin
      if (tx_acc) tx_mem_q[tx_wptr_q] <= wdata_i;
      if (rx_acc) rx_mem_q[rx_wptr_q] <= rx_tdata_i;
   end

   assign tx_tdata_o  = tx_mem_q[tx_rptr_q];
   assign tx_tvalid_o = ~tx_empty;
   assign rx_head_o   = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
   assign status_o    = {3'b000, tx_ovf_q, tx_empty, rx_ovf_q, tx_full, ~rx_empty};
   assign ctrl_o      = {6'b0, ctrl_q};
   assign rxcnt_o     = 8'(rx_cnt_q);
   assign irq_cond_o  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
endmodule

module aux_uart_bridge #(
   parameter int CHANNELS       = 2,
   parameter int FIFO_DEPTH     = 16,
   parameter int BASE_ADDR      = 16'hFF00,
   parameter int AUX_ADDR_WIDTH = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [AUX_ADDR_WIDTH-1:0] aux_adr_i,
   input  logic [7:0]                aux_dat_i,
   output logic [7:0]                aux_dat_o,
   input  logic                      aux_we_i,
   input  logic                      aux_re_i,
   output logic                      irq_o,
   output logic [8*CHANNELS-1:0]     tx_tdata_o,
   output logic [CHANNELS-1:0]       tx_tvalid_o,
   input  logic [CHANNELS-1:0]       tx_tready_i,
   input  logic [8*CHANNELS-1:0]     rx_tdata_i,
   input  logic [CHANNELS-1:0]       rx_tvalid_i,
   output logic [CHANNELS-1:0]       rx_tready_o
);
   localparam logic [AUX_ADDR_WIDTH-1:0] BASE = AUX_ADDR_WIDTH'(BASE_ADDR);

   logic [AUX_ADDR_WIDTH-1:0]  off;
   logic                       wr, rd;
   logic [CHANNELS-1:0]        hit, irq_cond;
   logic [CHANNELS-1:0][7:0]   head, status, ctrl, rxcnt;
   logic                       irq_q, irq_d;

   // both strobes high counts as a write only
   assign off = aux_adr_i - BASE;
   assign wr  = aux_we_i;
   assign rd  = aux_re_i & ~aux_we_i;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      assign hit[n] = (off[AUX_ADDR_WIDTH-1:2] == (AUX_ADDR_WIDTH-2)'(n));
      aux_uart_chan #(.FIFO_DEPTH(FIFO_DEPTH)) u_chan (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .data_wr_i   (wr & hit[n] & (off[1:0] == 2'd0)),
         .data_rd_i   (rd & hit[n] & (off[1:0] == 2'd0)),
         .status_wr_i (wr & hit[n] & (off[1:0] == 2'd1)),
         .ctrl_wr_i   (wr & hit[n] & (off[1:0] == 2'd2)),
         .wdata_i     (aux_dat_i),
         .tx_tdata_o  (tx_tdata_o[8*n +: 8]),
         .tx_tvalid_o (tx_tvalid_o[n]),
         .tx_tready_i (tx_tready_i[n]),
         .rx_tdata_i  (rx_tdata_i[8*n +: 8]),
         .rx_tvalid_i (rx_tvalid_i[n]),
         .rx_head_o   (head[n]),
         .status_o    (status[n]),
         .ctrl_o      (ctrl[n]),
         .rxcnt_o     (rxcnt[n]),
         .irq_cond_o  (irq_cond[n])
      );
   end

   // zero-latency read mux; 0x00 when idle or unmapped
   always_comb begin
      aux_dat_o = 8'h00;
      for (int n = 0; n < CHANNELS; n++) begin
         if (rd && hit[n]) begin
            case (off[1:0])
               2'd0:    aux_dat_o = head[n];
               2'd1:    aux_dat_o = status[n];
               2'd2:    aux_dat_o = ctrl[n];
               default: aux_dat_o = rxcnt[n];
            endcase
         end
      end
      irq_d = |irq_cond;
   end

   // registered interrupt
   always_ff @(posedge clk_i) begin
      if (reset_i) irq_q <= 1'b0;
      else         irq_q <= irq_d;
   end

   assign irq_o       = irq_q;
   assign rx_tready_o = '1;
endmodule
